// File: rtl/axis_pkt_rr_arb.sv
// Packet-atomic round-robin merge of two sample-level AXI streams onto one,
// with per-port packet quotas, an enable mask and forwarded-packet counters.
module axis_pkt_rr_arb #(
    parameter int WIDTH      = 32,
    parameter int USER_WIDTH = 128,
    parameter int SR_BASE    = 128
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  set_stb,
    input  logic [7:0]            set_addr,
    input  logic [31:0]           set_data,
    input  logic [WIDTH-1:0]      i0_tdata,
    input  logic [USER_WIDTH-1:0] i0_tuser,
    input  logic                  i0_tlast,
    input  logic                  i0_tvalid,
    output logic                  i0_tready,
    input  logic [WIDTH-1:0]      i1_tdata,
    input  logic [USER_WIDTH-1:0] i1_tuser,
    input  logic                  i1_tlast,
    input  logic                  i1_tvalid,
    output logic                  i1_tready,
    output logic [WIDTH-1:0]      o_tdata,
    output logic [USER_WIDTH-1:0] o_tuser,
    output logic                  o_tlast,
    output logic                  o_tvalid,
    input  logic                  o_tready,
    output logic                  o_src,
    output logic [15:0]           pkt_cnt0,
    output logic [15:0]           pkt_cnt1
);

    localparam logic [7:0] ADDR_QUOTA0 = 8'(SR_BASE);
    localparam logic [7:0] ADDR_QUOTA1 = 8'(SR_BASE + 1);
    localparam logic [7:0] ADDR_ENABLE = 8'(SR_BASE + 2);

    typedef enum logic [1:0] {S_IDLE, S_GRANT0, S_GRANT1} state_t;

    state_t                r_state;
    logic [3:0]            r_quota0;
    logic [3:0]            r_quota1;
    logic [3:0]            r_quota_left;
    logic [1:0]            r_enable;
    logic                  r_last_grant;
    logic [15:0]           r_cnt0;
    logic [15:0]           r_cnt1;
    logic [WIDTH-1:0]      r_tdata;
    logic [USER_WIDTH-1:0] r_tuser;
    logic                  r_tlast;
    logic                  r_tvalid;
    logic                  r_src;

    logic                  w_out_free;
    logic                  w_gnt0;
    logic                  w_gnt1;
    logic                  w_cur;
    logic                  w_in_valid;
    logic                  w_in_last;
    logic [WIDTH-1:0]      w_in_data;
    logic [USER_WIDTH-1:0] w_in_user;
    logic                  w_accept;
    logic                  w_cand0;
    logic                  w_cand1;
    logic                  w_cur_en;
    logic                  w_other_cand;
    logic [3:0]            w_quota_dec;
    logic [3:0]            w_set_quota;
    logic                  w_unused;

    assign w_out_free   = o_tready || !r_tvalid;
    assign w_gnt0       = (r_state == S_GRANT0);
    assign w_gnt1       = (r_state == S_GRANT1);
    assign w_cur        = w_gnt1;
    assign w_in_valid   = w_gnt0 ? i0_tvalid : (w_gnt1 && i1_tvalid);
    assign w_in_last    = w_cur ? i1_tlast : i0_tlast;
    assign w_in_data    = w_cur ? i1_tdata : i0_tdata;
    assign w_in_user    = w_cur ? i1_tuser : i0_tuser;
    assign w_accept     = w_in_valid && w_out_free;
    assign w_cand0      = i0_tvalid && r_enable[0];
    assign w_cand1      = i1_tvalid && r_enable[1];
    assign w_cur_en     = w_cur ? r_enable[1] : r_enable[0];
    assign w_other_cand = w_cur ? w_cand0 : w_cand1;
    assign w_quota_dec  = r_quota_left - 4'd1;
    assign w_set_quota  = (set_data[3:0] == 4'd0) ? 4'd1 : set_data[3:0];
    assign w_unused     = ^set_data[31:4];

    assign i0_tready = w_gnt0 && w_out_free;
    assign i1_tready = w_gnt1 && w_out_free;
    assign o_tdata   = r_tdata;
    assign o_tuser   = r_tuser;
    assign o_tlast   = r_tlast;
    assign o_tvalid  = r_tvalid;
    assign o_src     = r_src;
    assign pkt_cnt0  = r_cnt0;
    assign pkt_cnt1  = r_cnt1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_quota0 <= 4'd1;
            r_quota1 <= 4'd1;
            r_enable <= 2'b11;
        end else if (set_stb) begin
            if (set_addr == ADDR_QUOTA0) r_quota0 <= w_set_quota;
            if (set_addr == ADDR_QUOTA1) r_quota1 <= w_set_quota;
            if (set_addr == ADDR_ENABLE) r_enable <= set_data[1:0];
        end
    end

    // Single output stage; contents stay frozen while the sink stalls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tdata  <= '0;
            r_tuser  <= '0;
            r_tlast  <= 1'b0;
            r_tvalid <= 1'b0;
            r_src    <= 1'b0;
        end else if (w_accept) begin
            r_tdata  <= w_in_data;
            r_tuser  <= w_in_user;
            r_tlast  <= w_in_last;
            r_tvalid <= 1'b1;
            r_src    <= w_cur;
        end else if (o_tready) begin
            r_tvalid <= 1'b0;
        end
    end

    // Grants only move on an accepted tlast, so packets are never split.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_quota_left <= 4'd0;
            r_last_grant <= 1'b1;
            r_cnt0       <= 16'd0;
            r_cnt1       <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_cand0 && (!w_cand1 || r_last_grant)) begin
                        r_state      <= S_GRANT0;
                        r_quota_left <= r_quota0;
                    end else if (w_cand1) begin
                        r_state      <= S_GRANT1;
                        r_quota_left <= r_quota1;
                    end
                end
                S_GRANT0, S_GRANT1: begin
                    if (w_accept && w_in_last) begin
                        if (w_cur) r_cnt1 <= r_cnt1 + 16'd1;
                        else       r_cnt0 <= r_cnt0 + 16'd1;
                        if ((w_quota_dec != 4'd0) && w_cur_en && w_in_valid) begin
                            r_quota_left <= w_quota_dec;
                        end else if (w_other_cand) begin
                            r_state      <= w_cur ? S_GRANT0 : S_GRANT1;
                            r_last_grant <= w_cur;
                            r_quota_left <= w_cur ? r_quota0 : r_quota1;
                        end else begin
                            r_state      <= S_IDLE;
                            r_last_grant <= w_cur;
                            r_quota_left <= w_quota_dec;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_pkt_rr_arb.sv
// Randomized bench for axis_pkt_rr_arb: a packet-order model built from the
// round-robin/quota rules predicts the merged output stream.
module tb_axis_pkt_rr_arb;

    localparam int W = 32;
    localparam int UW = 128;
    localparam logic [7:0] SRB = 8'd128;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic set_stb = 1'b0;
    logic [7:0] set_addr = '0;
    logic [31:0] set_data = '0;
    logic [W-1:0] i0_tdata, i1_tdata, o_tdata;
    logic [UW-1:0] i0_tuser, i1_tuser, o_tuser;
    logic i0_tlast, i1_tlast, o_tlast;
    logic i0_tvalid, i1_tvalid, o_tvalid;
    logic i0_tready, i1_tready, o_tready;
    logic o_src;
    logic [15:0] pkt_cnt0, pkt_cnt1;

    always #5 clk = ~clk;

    axis_pkt_rr_arb #(.WIDTH(W), .USER_WIDTH(UW), .SR_BASE(128)) dut (
        .clk(clk), .reset_n(reset_n),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .i0_tdata(i0_tdata), .i0_tuser(i0_tuser), .i0_tlast(i0_tlast),
        .i0_tvalid(i0_tvalid), .i0_tready(i0_tready),
        .i1_tdata(i1_tdata), .i1_tuser(i1_tuser), .i1_tlast(i1_tlast),
        .i1_tvalid(i1_tvalid), .i1_tready(i1_tready),
        .o_tdata(o_tdata), .o_tuser(o_tuser), .o_tlast(o_tlast),
        .o_tvalid(o_tvalid), .o_tready(o_tready), .o_src(o_src),
        .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
    );

    typedef struct packed {
        logic [W-1:0]  d;
        logic [UW-1:0] u;
        logic          l;
        logic          s;
    } beat_t;

    beat_t q0[$], q1[$];
    beat_t exp0[$], exp1[$];
    beat_t outLog[$];
    int    outCyc[$];
    beat_t expQ[$];
    int    seqQ[$];

    int cyc = 0;
    int nChecks = 0;
    int nPass = 0;
    bit engEn = 1'b0;
    bit hs0, hs1;
    int readyPct = 100;
    int txPkts0, txBeats1, firstHsCyc, firstValidCyc, stallViol, i1ReadySeen;
    bit stallHeld;
    beat_t stallBeat;

    // Drives both sources and the sink at negedge; handshakes are evaluated
    // just after so they describe the upcoming posedge.
    initial begin : engine
        beat_t o;
        i0_tvalid = 0; i1_tvalid = 0; o_tready = 1;
        i0_tdata = '0; i0_tuser = '0; i0_tlast = 0;
        i1_tdata = '0; i1_tuser = '0; i1_tlast = 0;
        hs0 = 0; hs1 = 0; stallHeld = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!engEn) begin
                i0_tvalid = 0; i1_tvalid = 0; o_tready = 1;
                hs0 = 0; hs1 = 0; stallHeld = 0;
            end else begin
                if (hs0 && q0.size() > 0) void'(q0.pop_front());
                if (hs1 && q1.size() > 0) void'(q1.pop_front());
                if (!(i0_tvalid && !hs0)) begin
                    if (q0.size() > 0) begin
                        {i0_tdata, i0_tuser, i0_tlast} = {q0[0].d, q0[0].u, q0[0].l};
                        i0_tvalid = 1;
                    end else i0_tvalid = 0;
                end
                if (!(i1_tvalid && !hs1)) begin
                    if (q1.size() > 0) begin
                        {i1_tdata, i1_tuser, i1_tlast} = {q1[0].d, q1[0].u, q1[0].l};
                        i1_tvalid = 1;
                    end else i1_tvalid = 0;
                end
                o_tready = ($urandom_range(99) < readyPct);
                #1;
                hs0 = i0_tvalid && i0_tready;
                hs1 = i1_tvalid && i1_tready;
                if (hs0 && i0_tlast) txPkts0++;
                if (hs1) txBeats1++;
                if (hs0 && firstHsCyc < 0) firstHsCyc = cyc;
                if (o_tvalid && firstValidCyc < 0) firstValidCyc = cyc;
                if (i1_tready) i1ReadySeen++;
                o.d = o_tdata; o.u = o_tuser; o.l = o_tlast; o.s = o_src;
                if (stallHeld && (!o_tvalid || o !== stallBeat)) stallViol++;
                if (o_tvalid && o_tready) begin
                    outLog.push_back(o);
                    outCyc.push_back(cyc);
                end
                stallHeld = o_tvalid && !o_tready;
                stallBeat = o;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void addPkt(input int port, input int n);
        beat_t x;
        for (int b = 0; b < n; b++) begin
            x.d = $urandom;
            x.u = {$urandom, $urandom, $urandom, $urandom};
            x.l = (b == n - 1);
            x.s = 1'(port);
            if (port == 0) begin q0.push_back(x); exp0.push_back(x); end
            else           begin q1.push_back(x); exp1.push_back(x); end
        end
    endfunction

    // Packet source order for two saturated ports under round-robin with quotas.
    function automatic void rrOrder(input int qa, input int qb, input int n0, input int n1);
        int r0, r1, p, t;
        r0 = n0; r1 = n1; p = 0;
        while (r0 + r1 > 0) begin
            t = (p == 0) ? ((qa < r0) ? qa : r0) : ((qb < r1) ? qb : r1);
            for (int k = 0; k < t; k++) seqQ.push_back(p);
            if (p == 0) r0 -= t; else r1 -= t;
            p ^= 1;
        end
    endfunction

    function automatic void expandOrder();
        beat_t c0[$], c1[$];
        beat_t b;
        bit done;
        c0 = exp0; c1 = exp1;
        expQ.delete();
        foreach (seqQ[i]) begin
            done = 0;
            while (!done) begin
                if (seqQ[i] == 0) begin
                    if (c0.size() == 0) break;
                    b = c0.pop_front();
                end else begin
                    if (c1.size() == 0) break;
                    b = c1.pop_front();
                end
                expQ.push_back(b);
                done = b.l;
            end
        end
    endfunction

    task automatic writeReg(input logic [7:0] a, input logic [31:0] d);
        set_stb = 1; set_addr = a; set_data = d;
        @(posedge clk); #1;
        set_stb = 0; set_addr = '0; set_data = '0;
    endtask

    task automatic resetDut();
        engEn = 0;
        reset_n = 0;
        repeat (3) @(negedge clk);
        q0.delete(); q1.delete(); exp0.delete(); exp1.delete();
        outLog.delete(); outCyc.delete(); seqQ.delete(); expQ.delete();
        txPkts0 = 0; txBeats1 = 0; firstHsCyc = -1; firstValidCyc = -1;
        stallViol = 0; i1ReadySeen = 0; readyPct = 100;
        #2;
        reset_n = 1;
        engEn = 1;
    endtask

    task automatic waitBeats(input int n, input int budget);
        for (int k = 0; k < budget && outLog.size() < n; k++) @(negedge clk);
        repeat (4) @(negedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset_n = 0;
        #3;
        nChecks++;
        if ({o_tvalid, o_tlast, o_src, i0_tready, i1_tready} !== 5'b0) $display("[TB] FAIL reset_ctrl got %b required 00000", {o_tvalid, o_tlast, o_src, i0_tready, i1_tready});
        else nPass++;
        nChecks++;
        if (o_tdata !== '0 || o_tuser !== '0) $display("[TB] FAIL reset_data got %h/%h required 0", o_tdata, o_tuser);
        else nPass++;
        nChecks++;
        if (pkt_cnt0 !== 16'd0 || pkt_cnt1 !== 16'd0) $display("[TB] FAIL reset_cnt got %0d/%0d required 0/0", pkt_cnt0, pkt_cnt1);
        else nPass++;
        resetDut();
        repeat (3) @(negedge clk);
        #2;
        nChecks++;
        if (o_tvalid !== 1'b0 || outLog.size() != 0) $display("[TB] FAIL idle_after_reset got valid=%b beats=%0d required 0/0", o_tvalid, outLog.size());
        else nPass++;
    endtask

    task automatic test_port0_only();
        beat_t g;
        resetDut();
        writeReg(SRB, 32'd3);
        for (int p = 0; p < 3; p++) addPkt(0, 4);
        rrOrder(3, 1, 3, 0);
        expandOrder();
        waitBeats(12, 200);
        nChecks++;
        if (outLog.size() != expQ.size()) $display("[TB] FAIL p0_count got %0d required %0d", outLog.size(), expQ.size());
        else nPass++;
        foreach (expQ[k]) begin
            g = (k < outLog.size()) ? outLog[k] : '0;
            nChecks++;
            if (g !== expQ[k]) $display("[TB] FAIL p0_beat%0d got d=%h s=%0d l=%0d required d=%h s=%0d l=%0d", k, g.d, g.s, g.l, expQ[k].d, expQ[k].s, expQ[k].l);
            else nPass++;
        end
        nChecks++;
        if (firstValidCyc != firstHsCyc + 1) $display("[TB] FAIL p0_latency got %0d required %0d", firstValidCyc - firstHsCyc, 1);
        else nPass++;
        nChecks++;
        if (outCyc.size() < 12 || outCyc[11] - outCyc[0] != 11) $display("[TB] FAIL p0_no_bubbles got span=%0d required 11", (outCyc.size() < 12) ? -1 : outCyc[11] - outCyc[0]);
        else nPass++;
        nChecks++;
        if (pkt_cnt0 !== 16'd3 || pkt_cnt1 !== 16'd0) $display("[TB] FAIL p0_cnt got %0d/%0d required 3/0", pkt_cnt0, pkt_cnt1);
        else nPass++;
    endtask

    task automatic test_fairness();
        beat_t g;
        resetDut();
        for (int p = 0; p < 4; p++) begin addPkt(0, 2); addPkt(1, 2); end
        rrOrder(1, 1, 4, 4);
        expandOrder();
        waitBeats(16, 300);
        nChecks++;
        if (outLog.size() != expQ.size()) $display("[TB] FAIL rr_count got %0d required %0d", outLog.size(), expQ.size());
        else nPass++;
        foreach (expQ[k]) begin
            g = (k < outLog.size()) ? outLog[k] : '0;
            nChecks++;
            if (g !== expQ[k]) $display("[TB] FAIL rr_beat%0d got d=%h s=%0d l=%0d required d=%h s=%0d l=%0d", k, g.d, g.s, g.l, expQ[k].d, expQ[k].s, expQ[k].l);
            else nPass++;
        end
        nChecks++;
        if (pkt_cnt0 !== 16'd4 || pkt_cnt1 !== 16'd4) $display("[TB] FAIL rr_cnt got %0d/%0d required 4/4", pkt_cnt0, pkt_cnt1);
        else nPass++;
    endtask

    task automatic test_quota_change();
        beat_t g;
        resetDut();
        writeReg(SRB, 32'd3);
        writeReg(SRB + 8'd1, 32'd0);
        for (int p = 0; p < 5; p++) addPkt(0, 4);
        for (int p = 0; p < 3; p++) addPkt(1, 4);
        for (int k = 0; k < 200 && txPkts0 < 1; k++) begin @(negedge clk); #2; end
        writeReg(SRB, 32'd1);
        seqQ = '{0, 0, 0, 1};
        rrOrder(1, 1, 2, 2);
        expandOrder();
        waitBeats(32, 400);
        nChecks++;
        if (outLog.size() != expQ.size()) $display("[TB] FAIL quota_count got %0d required %0d", outLog.size(), expQ.size());
        else nPass++;
        foreach (expQ[k]) begin
            g = (k < outLog.size()) ? outLog[k] : '0;
            nChecks++;
            if (g !== expQ[k]) $display("[TB] FAIL quota_beat%0d got d=%h s=%0d l=%0d required d=%h s=%0d l=%0d", k, g.d, g.s, g.l, expQ[k].d, expQ[k].s, expQ[k].l);
            else nPass++;
        end
        nChecks++;
        if (pkt_cnt0 !== 16'd5 || pkt_cnt1 !== 16'd3) $display("[TB] FAIL quota_cnt got %0d/%0d required 5/3", pkt_cnt0, pkt_cnt1);
        else nPass++;
    endtask

    task automatic test_stall_switch();
        beat_t g;
        int total;
        resetDut();
        readyPct = 50;
        total = 0;
        for (int p = 0; p < 6; p++) begin
            int n0, n1;
            n0 = $urandom_range(5, 1); n1 = $urandom_range(5, 1);
            addPkt(0, n0); addPkt(1, n1);
            total += n0 + n1;
        end
        rrOrder(1, 1, 6, 6);
        expandOrder();
        waitBeats(total, 2000);
        readyPct = 100;
        nChecks++;
        if (outLog.size() != expQ.size()) $display("[TB] FAIL stall_count got %0d required %0d", outLog.size(), expQ.size());
        else nPass++;
        foreach (expQ[k]) begin
            g = (k < outLog.size()) ? outLog[k] : '0;
            nChecks++;
            if (g !== expQ[k]) $display("[TB] FAIL stall_beat%0d got d=%h s=%0d l=%0d required d=%h s=%0d l=%0d", k, g.d, g.s, g.l, expQ[k].d, expQ[k].s, expQ[k].l);
            else nPass++;
        end
        nChecks++;
        if (stallViol != 0) $display("[TB] FAIL stall_stable got %0d changes required 0", stallViol);
        else nPass++;
        nChecks++;
        if (pkt_cnt0 !== 16'd6 || pkt_cnt1 !== 16'd6) $display("[TB] FAIL stall_cnt got %0d/%0d required 6/6", pkt_cnt0, pkt_cnt1);
        else nPass++;
    endtask

    task automatic test_enable_mid();
        beat_t g;
        resetDut();
        addPkt(0, 2); addPkt(0, 2);
        addPkt(1, 6); addPkt(1, 6);
        for (int k = 0; k < 200 && txBeats1 < 2; k++) begin @(negedge clk); #2; end
        writeReg(SRB + 8'd2, 32'd1);
        seqQ = '{0, 1, 0};
        expandOrder();
        waitBeats(10, 200);
        i1ReadySeen = 0;
        repeat (20) @(negedge clk);
        #2;
        nChecks++;
        if (outLog.size() != expQ.size()) $display("[TB] FAIL en_count got %0d required %0d", outLog.size(), expQ.size());
        else nPass++;
        foreach (expQ[k]) begin
            g = (k < outLog.size()) ? outLog[k] : '0;
            nChecks++;
            if (g !== expQ[k]) $display("[TB] FAIL en_beat%0d got d=%h s=%0d l=%0d required d=%h s=%0d l=%0d", k, g.d, g.s, g.l, expQ[k].d, expQ[k].s, expQ[k].l);
            else nPass++;
        end
        nChecks++;
        if (i1ReadySeen != 0 || q1.size() != 6) $display("[TB] FAIL en_port1_blocked got ready=%0d left=%0d required 0/6", i1ReadySeen, q1.size());
        else nPass++;
        nChecks++;
        if (pkt_cnt0 !== 16'd2 || pkt_cnt1 !== 16'd1) $display("[TB] FAIL en_cnt got %0d/%0d required 2/1", pkt_cnt0, pkt_cnt1);
        else nPass++;
    endtask

    task automatic test_reset_mid();
        beat_t g;
        resetDut();
        writeReg(SRB + 8'd1, 32'd4);
        addPkt(1, 2); addPkt(1, 8);
        for (int k = 0; k < 200 && txBeats1 < 5; k++) begin @(negedge clk); #2; end
        reset_n = 0;
        #1;
        nChecks++;
        if (o_tvalid !== 1'b0 || i1_tready !== 1'b0 || i0_tready !== 1'b0) $display("[TB] FAIL rstmid_drop got v=%b r0=%b r1=%b required 0", o_tvalid, i0_tready, i1_tready);
        else nPass++;
        nChecks++;
        if (pkt_cnt1 !== 16'd0) $display("[TB] FAIL rstmid_cnt got %0d required 0", pkt_cnt1);
        else nPass++;
        resetDut();
        addPkt(0, 2); addPkt(0, 2);
        addPkt(1, 2); addPkt(1, 2);
        rrOrder(1, 1, 2, 2);
        expandOrder();
        waitBeats(8, 200);
        nChecks++;
        if (outLog.size() != expQ.size()) $display("[TB] FAIL rstmid_count got %0d required %0d", outLog.size(), expQ.size());
        else nPass++;
        foreach (expQ[k]) begin
            g = (k < outLog.size()) ? outLog[k] : '0;
            nChecks++;
            if (g !== expQ[k]) $display("[TB] FAIL rstmid_beat%0d got d=%h s=%0d l=%0d required d=%h s=%0d l=%0d", k, g.d, g.s, g.l, expQ[k].d, expQ[k].s, expQ[k].l);
            else nPass++;
        end
    endtask

    initial begin : main
        test_reset();
        test_port0_only();
        test_fairness();
        test_quota_change();
        test_stall_switch();
        test_enable_mid();
        test_reset_mid();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
